sort_frame_client: RTL and testbench

SORT_FRAME_CLIENT -- requirements
Module: sort_frame_client

---
 rtl/sort_frame_pkg.sv | 30 +++
 rtl/sort_frame_rx_decoder.sv | 115 +++++++++++
 rtl/sort_frame_client.sv | 144 ++++++++++++++
 tb/tb_sort_frame_client.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_frame_pkg.sv
// Shared definitions for the sort-frame client and the sorter bridge.
// Frame format: 16-bit length/header, then per value a low byte followed
// by a zero-extended high byte.
package sort_frame_pkg;

  typedef enum logic [2:0] {
    T_IDLE,
    T_LEN_LO,
    T_LEN_HI,
    T_VAL_LO,
    T_VAL_HI,
    T_FIN
  } tx_state_e;

  typedef enum logic [2:0] {
    R_IDLE,
    R_HDR_LO,
    R_HDR_HI,
    R_VAL_LO,
    R_VAL_HI,
    R_FIN
  } rx_state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;

  // Multi-byte fields travel little-endian: low byte first.
  localparam bit LOW_BYTE_FIRST = 1'b1;

endpackage

// File: rtl/sort_frame_rx_decoder.sv
// Receive side of the sort-frame client: parses the reply header and the
// value byte pairs, presents decoded values on a result register and raises
// sticky length / range / order errors.
// Ports: start_i/length_i arm a frame, finish_i returns to idle, rx_* byte
// stream in, result_* decoded values out, fin_o = all results delivered.
module sort_frame_rx_decoder
  import sort_frame_pkg::*;
#(
  parameter int VALUE_WIDTH = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [LEN_W-1:0]       length_i,
  input  logic                   finish_i,
  input  logic [BYTE_W-1:0]      rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [VALUE_WIDTH-1:0] result_o,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic                   fin_o,
  output logic                   err_len_o,
  output logic                   err_order_o,
  output logic                   err_range_o
);

  rx_state_e               state_q;
  logic [LEN_W-1:0]        len_q;
  logic [COUNT_WIDTH-1:0]  cnt_q;
  logic [BYTE_W-1:0]       lo_q;
  logic [VALUE_WIDTH-1:0]  result_q;
  logic                    result_valid_q;
  logic [VALUE_WIDTH-1:0]  prev_q;
  logic                    prev_valid_q;
  logic                    err_len_q, err_order_q, err_range_q;

  logic                    rx_fire;
  logic [LEN_W-1:0]        header;
  logic [VALUE_WIDTH-1:0]  rx_value;
  logic                    range_bad;

  // The high byte may only be taken when the result register can hold it.
  assign rx_ready_o = (state_q == R_HDR_LO) || (state_q == R_HDR_HI) ||
                      (state_q == R_VAL_LO) ||
                      ((state_q == R_VAL_HI) && (!result_valid_q || result_ready_i));
  assign rx_fire    = rx_valid_i && rx_ready_o;

  assign header    = LOW_BYTE_FIRST ? {rx_data_i, lo_q} : {lo_q, rx_data_i};
  // Truncation keeps hi[VW-9:0]; any dropped high bit is a range error.
  assign rx_value  = VALUE_WIDTH'({rx_data_i, lo_q});
  assign range_bad = (rx_data_i >> (VALUE_WIDTH - 8)) != '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= R_IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      lo_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      prev_q         <= '0;
      prev_valid_q   <= 1'b0;
      err_len_q      <= 1'b0;
      err_order_q    <= 1'b0;
      err_range_q    <= 1'b0;
    end else begin
      if (result_valid_q && result_ready_i) result_valid_q <= 1'b0;
      case (state_q)
        R_IDLE: if (start_i) begin
          len_q        <= length_i;
          err_len_q    <= 1'b0;
          err_order_q  <= 1'b0;
          err_range_q  <= 1'b0;
          prev_valid_q <= 1'b0;
          state_q      <= R_HDR_LO;
        end
        R_HDR_LO: if (rx_fire) begin
          lo_q    <= rx_data_i;
          state_q <= R_HDR_HI;
        end
        R_HDR_HI: if (rx_fire) begin
          if (header != len_q) err_len_q <= 1'b1;
          cnt_q   <= COUNT_WIDTH'(len_q);
          state_q <= (len_q == '0) ? R_FIN : R_VAL_LO;
        end
        R_VAL_LO: if (rx_fire) begin
          lo_q    <= rx_data_i;
          state_q <= R_VAL_HI;
        end
        R_VAL_HI: if (rx_fire) begin
          result_q       <= rx_value;
          result_valid_q <= 1'b1;
          if (range_bad) err_range_q <= 1'b1;
          if (prev_valid_q && (rx_value < prev_q)) err_order_q <= 1'b1;
          prev_q       <= rx_value;
          prev_valid_q <= 1'b1;
          cnt_q        <= cnt_q - COUNT_WIDTH'(1);
          state_q      <= (cnt_q == COUNT_WIDTH'(1)) ? R_FIN : R_VAL_LO;
        end
        R_FIN: if (finish_i) state_q <= R_IDLE;
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign fin_o          = (state_q == R_FIN) && !result_valid_q;
  assign err_len_o      = err_len_q;
  assign err_order_o    = err_order_q;
  assign err_range_o    = err_range_q;

endmodule

// File: rtl/sort_frame_client.sv
// Sort-frame client: serialises a length header and unsorted values onto a
// byte stream toward the sorter bridge and decodes the sorted reply.
// Ports: start_i/length_i begin a frame, value_* unsorted values in, tx_*
// bytes out, rx_* bytes in, result_* sorted values out, busy_o/done_o frame
// status, err_* sticky flags cleared on the next accepted start.
module sort_frame_client
  import sort_frame_pkg::*;
#(
  parameter int VALUE_WIDTH = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic [LEN_W-1:0]       length_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  input  logic                   value_valid_i,
  output logic                   value_ready_o,
  output logic [BYTE_W-1:0]      tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  input  logic [BYTE_W-1:0]      rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [VALUE_WIDTH-1:0] result_o,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_len_o,
  output logic                   err_order_o,
  output logic                   err_range_o
);

  // Assertion is immediate through the async clear; release takes two edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  tx_state_e              tx_state_q;
  logic [BYTE_W-1:0]      tx_data_q;
  logic                   tx_valid_q;
  logic [LEN_W-1:0]       len_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [BYTE_W-1:0]      hold_hi_q;
  logic                   busy_q, done_q;

  logic start_acc, value_fire, rx_fin, finish;

  assign start_acc     = start_i && (tx_state_q == T_IDLE);
  assign value_ready_o = (tx_state_q == T_VAL_LO) && (!tx_valid_q || tx_ready_i);
  assign value_fire    = value_valid_i && value_ready_o;
  // Frame completes once the last tx byte has left and the decoder is drained.
  assign finish        = (tx_state_q == T_FIN) && !tx_valid_q && rx_fin;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= T_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      hold_hi_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (tx_state_q)
        T_IDLE: if (start_acc) begin
          len_q      <= length_i;
          busy_q     <= 1'b1;
          tx_data_q  <= LOW_BYTE_FIRST ? length_i[7:0] : length_i[15:8];
          tx_valid_q <= 1'b1;
          tx_state_q <= T_LEN_LO;
        end
        T_LEN_LO: if (tx_ready_i) begin
          tx_data_q  <= LOW_BYTE_FIRST ? len_q[15:8] : len_q[7:0];
          tx_state_q <= T_LEN_HI;
        end
        T_LEN_HI: if (tx_ready_i) begin
          tx_valid_q <= 1'b0;
          cnt_q      <= COUNT_WIDTH'(len_q);
          tx_state_q <= (len_q == '0) ? T_FIN : T_VAL_LO;
        end
        T_VAL_LO: begin
          // The register may still hold the previous high byte here.
          if (tx_ready_i) tx_valid_q <= 1'b0;
          if (value_fire) begin
            tx_data_q  <= value_i[7:0];
            tx_valid_q <= 1'b1;
            hold_hi_q  <= BYTE_W'(value_i >> 8);
            cnt_q      <= cnt_q - COUNT_WIDTH'(1);
            tx_state_q <= T_VAL_HI;
          end
        end
        T_VAL_HI: if (tx_ready_i) begin
          tx_data_q  <= hold_hi_q;
          tx_state_q <= (cnt_q == '0) ? T_FIN : T_VAL_LO;
        end
        T_FIN: begin
          if (tx_ready_i) tx_valid_q <= 1'b0;
          if (finish) begin
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            tx_state_q <= T_IDLE;
          end
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  sort_frame_rx_decoder #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_rx_decoder (
    .clk_i          (clk_i),
    .rst_ni         (rst_n),
    .start_i        (start_acc),
    .length_i       (length_i),
    .finish_i       (finish),
    .rx_data_i      (rx_data_i),
    .rx_valid_i     (rx_valid_i),
    .rx_ready_o     (rx_ready_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .fin_o          (rx_fin),
    .err_len_o      (err_len_o),
    .err_order_o    (err_order_o),
    .err_range_o    (err_range_o)
  );

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_sort_frame_client.sv
module tb_sort_frame_client;
  localparam int VW = 10;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [15:0]   length_i = '0;
  logic [VW-1:0] value_i = '0;
  logic          value_valid_i = 1'b0;
  logic          value_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b0;
  logic [7:0]    rx_data_i = '0;
  logic          rx_valid_i = 1'b0;
  logic          rx_ready_o;
  logic [VW-1:0] result_o;
  logic          result_valid_o;
  logic          result_ready_i = 1'b0;
  logic          busy_o, done_o, err_len_o, err_order_o, err_range_o;

  always #5 clk_i = ~clk_i;

  sort_frame_client #(.VALUE_WIDTH(VW), .COUNT_WIDTH(16)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .length_i(length_i),
    .value_i(value_i), .value_valid_i(value_valid_i), .value_ready_o(value_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .result_o(result_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_len_o(err_len_o),
    .err_order_o(err_order_o), .err_range_o(err_range_o)
  );

  int checks = 0;
  int failures = 0;

  int vq[$], rq[$], fv[$], fr[$];
  int exp_tx[$], exp_res[$], tx_got[$], res_got[$];
  int tx_idx = 0, res_idx = 0, done_cnt = 0;
  bit mon_en = 0, bp_en = 0, v_fire = 0, r_fire = 0;
  bit exp_el = 0, exp_eo = 0, exp_er = 0;
  bit prev_tx_stall = 0, prev_res_stall = 0;
  int prev_tx_data = 0, prev_res_data = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Input drivers: pop what the previous edge accepted, then offer the next item.
  always @(posedge clk_i) begin
    #1;
    if (v_fire && vq.size() > 0) void'(vq.pop_front());
    if (r_fire && rq.size() > 0) void'(rq.pop_front());
    v_fire = 0;
    r_fire = 0;
    value_valid_i  = vq.size() > 0;
    value_i        = (vq.size() > 0) ? VW'(vq[0]) : '0;
    rx_valid_i     = rq.size() > 0;
    rx_data_i      = (rq.size() > 0) ? 8'(rq[0]) : 8'h00;
    tx_ready_i     = bp_en ? ($urandom_range(0, 99) < 60) : 1'b1;
    result_ready_i = bp_en ? ($urandom_range(0, 99) < 50) : 1'b1;
  end

  // Compare process: every tx byte and result handshake against the model.
  always @(negedge clk_i) begin
    v_fire = value_valid_i && value_ready_o;
    r_fire = rx_valid_i && rx_ready_o;
    if (mon_en) begin
      if (prev_tx_stall) begin
        check("tx_hold_valid", int'(tx_valid_o), 1);
        check("tx_hold_data", int'(tx_data_o), prev_tx_data);
      end
      if (prev_res_stall) begin
        check("res_hold_valid", int'(result_valid_o), 1);
        check("res_hold_data", int'(result_o), prev_res_data);
      end
      if (tx_valid_o && tx_ready_i) begin
        check("tx_byte", int'(tx_data_o), (tx_idx < exp_tx.size()) ? exp_tx[tx_idx] : -1);
        tx_got.push_back(int'(tx_data_o));
        tx_idx++;
      end
      if (result_valid_o && result_ready_i) begin
        check("result", int'(result_o), (res_idx < exp_res.size()) ? exp_res[res_idx] : -1);
        res_got.push_back(int'(result_o));
        res_idx++;
      end
      prev_tx_stall  = tx_valid_o && !tx_ready_i;
      prev_tx_data   = int'(tx_data_o);
      prev_res_stall = result_valid_o && !result_ready_i;
      prev_res_data  = int'(result_o);
      if (done_o) begin
        done_cnt++;
        check("busy_at_done", int'(busy_o), 0);
      end
    end else begin
      prev_tx_stall  = 0;
      prev_res_stall = 0;
    end
  end

  // Bridge model: echo the length as header, then the values in ascending order.
  task automatic make_loopback(input int len);
    int s[$];
    int t;
    s = fv;
    for (int i = 0; i < s.size(); i++)
      for (int j = 0; j + 1 < s.size() - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    fr.delete();
    fr.push_back(len & 255);
    fr.push_back((len >> 8) & 255);
    foreach (s[i]) begin
      fr.push_back(s[i] & 255);
      fr.push_back(s[i] >> 8);
    end
  endtask

  // Client model: expected tx bytes, decoded results and error flags.
  task automatic build_model(input int len);
    int lo, hi, v;
    exp_tx.delete();
    exp_res.delete();
    exp_tx.push_back(len & 255);
    exp_tx.push_back((len >> 8) & 255);
    foreach (fv[i]) begin
      exp_tx.push_back(fv[i] & 255);
      exp_tx.push_back(fv[i] >> 8);
    end
    exp_el = (((fr[1] << 8) | fr[0]) != len);
    exp_er = 0;
    exp_eo = 0;
    for (int i = 0; i < len && (2*i + 3) < fr.size(); i++) begin
      lo = fr[2 + 2*i];
      hi = fr[3 + 2*i];
      v  = ((hi << 8) | lo) % (1 << VW);
      if (hi >= (1 << (VW - 8))) exp_er = 1;
      if (i > 0 && v < exp_res[i-1]) exp_eo = 1;
      exp_res.push_back(v);
    end
  endtask

  task automatic begin_frame(input int len, input bit bp);
    build_model(len);
    tx_got.delete();
    res_got.delete();
    tx_idx = 0;
    res_idx = 0;
    done_cnt = 0;
    @(posedge clk_i); #1;
    vq = fv;
    rq = fr;
    bp_en = bp;
    mon_en = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rx_ready_idle", int'(rx_ready_o), 0);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    length_i = 16'(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("first_byte_valid", int'(tx_valid_o), 1);
    check("busy_after_start", int'(busy_o), 1);
  endtask

  task automatic run_frame(input int len, input bit bp, input bit mid_start);
    begin_frame(len, bp);
    if (mid_start) begin
      @(posedge clk_i); #1;
      start_i = 1'b1;
      length_i = 16'd7;
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    for (int c = 0; c < 4000 && done_cnt == 0; c++) @(negedge clk_i);
    check("done_seen", (done_cnt > 0) ? 1 : 0, 1);
    repeat (3) @(negedge clk_i);
    check("done_once", done_cnt, 1);
    check("tx_count", tx_idx, exp_tx.size());
    check("res_count", res_idx, exp_res.size());
    check("values_left", vq.size(), 0);
    check("err_len", int'(err_len_o), int'(exp_el));
    check("err_order", int'(err_order_o), int'(exp_eo));
    check("err_range", int'(err_range_o), int'(exp_er));
    check("busy_end", int'(busy_o), 0);
    bp_en = 0;
    rq.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_valid"}, int'(tx_valid_o), 0);
    check({tag, "_rx_ready"}, int'(rx_ready_o), 0);
    check({tag, "_value_ready"}, int'(value_ready_o), 0);
    check({tag, "_result_valid"}, int'(result_valid_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_err_len"}, int'(err_len_o), 0);
    check({tag, "_err_order"}, int'(err_order_o), 0);
    check({tag, "_err_range"}, int'(err_range_o), 0);
  endtask

  task automatic frame_a_literals();
    int lit_tx[8];
    int lit_res[3];
    lit_tx  = '{3, 0, 5, 0, 1, 0, 255, 3};
    lit_res = '{1, 5, 1023};
    for (int i = 0; i < 8; i++)
      check("lit_tx", (i < tx_got.size()) ? tx_got[i] : -1, lit_tx[i]);
    for (int i = 0; i < 3; i++)
      check("lit_res", (i < res_got.size()) ? res_got[i] : -1, lit_res[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #2;
    check_outputs_zero("in_reset");
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check_outputs_zero("after_release");

    // Frame A: loopback sort, with an ignored start while busy.
    fv = '{5, 1, 1023};
    make_loopback(3);
    run_frame(3, 1'b0, 1'b1);
    frame_a_literals();

    // Empty frame.
    fv.delete();
    fr = '{0, 0};
    run_frame(0, 1'b0, 1'b0);
    check("lit_len0_tx_count", tx_got.size(), 2);
    check("lit_len0_res_count", res_got.size(), 0);

    // Header mismatch: only the captured length of values is consumed.
    fv = '{10, 20};
    fr = '{3, 0, 10, 0, 20, 0};
    run_frame(2, 1'b0, 1'b0);
    check("lit_len_err", int'(err_len_o), 1);
    check("lit_len_err_results", res_got.size(), 2);

    // Descending reply values.
    fv = '{4, 7};
    fr = '{2, 0, 7, 0, 4, 0};
    run_frame(2, 1'b0, 1'b0);
    check("lit_order_err", int'(err_order_o), 1);

    // High byte beyond the value width: delivered truncated.
    fv = '{291};
    fr = '{1, 0, 35, 4};
    run_frame(1, 1'b0, 1'b0);
    check("lit_range_err", int'(err_range_o), 1);
    check("lit_range_value", (res_got.size() > 0) ? res_got[0] : -1, 35);
    check("lit_order_cleared", int'(err_order_o), 0);

    // Sixteen random values under random backpressure.
    fv.delete();
    for (int i = 0; i < 16; i++) fv.push_back(int'($urandom_range(0, 1023)));
    make_loopback(16);
    run_frame(16, 1'b1, 1'b0);

    // Reset in the middle of a frame.
    fv = '{5, 1, 1023};
    make_loopback(3);
    begin_frame(3, 1'b0);
    for (int c = 0; c < 200 && tx_idx < 3; c++) @(negedge clk_i);
    check("reset_pre_bytes", (tx_idx >= 3) ? 1 : 0, 1);
    #2;
    mon_en = 0;
    reset_ni = 1'b0;
    vq.delete();
    rq.delete();
    v_fire = 0;
    r_fire = 0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      check("idle_after_reset_tx", int'(tx_valid_o), 0);
    end
    check_outputs_zero("post_reset");

    fv = '{5, 1, 1023};
    make_loopback(3);
    run_frame(3, 1'b0, 1'b0);
    frame_a_literals();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
